// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam int INST_W = 32;

  // addi x0,x0,0 -- what decode sees whenever the IF/ID register is empty
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus: single-outstanding request strobe with a valid-qualified response.
interface instruction_fetch_if;
  import if_pkg::*;

  logic              imem_req;
  logic [INST_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instruction_fetch_if_id_skid.sv
// IF/ID output register backed by a one-entry hold register so a response
// arriving while decode is stalled is never lost.
module if_id_skid
  import if_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  input  logic [INST_W-1:0] in_pc,
  output logic              in_ready,
  input  logic              decode_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [INST_W-1:0] pc_out,
  output logic              inst_valid,
  output logic              hold_valid
);

  logic [INST_W-1:0] hold_inst;
  logic [INST_W-1:0] hold_pc;

  assign in_ready = !inst_valid || decode_ready;

  // Flush only shapes next-cycle contents; an instruction leaving this cycle still counts as taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_out   <= NOP_INST;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      hold_inst  <= NOP_INST;
      hold_pc    <= '0;
      hold_valid <= 1'b0;
    end else if (flush) begin
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
      hold_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      inst_out   <= in_inst;
      pc_out     <= in_pc;
      inst_valid <= 1'b1;
    end else if (in_valid) begin
      hold_inst  <= in_inst;
      hold_pc    <= in_pc;
      hold_valid <= 1'b1;
    end else if (hold_valid && decode_ready) begin
      inst_out   <= hold_inst;
      pc_out     <= hold_pc;
      inst_valid <= 1'b1;
      hold_valid <= 1'b0;
    end else if (inst_valid && decode_ready) begin
      inst_out   <= NOP_INST;
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC and the request FSM, feeds decode through if_id_skid.
module instruction_fetch
  import if_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master imem,
  input  logic                decode_ready,
  input  logic                branch_taken,
  input  logic [INST_W-1:0]   branch_target,
  output logic [INST_W-1:0]   inst_out,
  output logic [INST_W-1:0]   pc_out,
  output logic                inst_valid
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] pc_next;
  logic              load_valid;
  logic              slot_free;
  logic              hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // A redirect from REQ or a response-less WAIT leaves a request in flight, so it must be drained.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (branch_taken) begin
      pc_next = branch_target & ~32'h3;
      unique case (state)
        REQ:     state_next = DRAIN;
        WAIT:    state_next = imem.imem_rvalid ? REQ : DRAIN;
        HOLD:    state_next = REQ;
        DRAIN:   state_next = imem.imem_rvalid ? REQ : DRAIN;
        default: state_next = REQ;
      endcase
    end else begin
      unique case (state)
        REQ:     state_next = WAIT;
        WAIT: begin
          if (imem.imem_rvalid) begin
            pc_next    = pc + 32'd4;
            state_next = slot_free ? REQ : HOLD;
          end
        end
        HOLD: begin
          if (decode_ready || !hold_valid) state_next = REQ;
        end
        DRAIN: begin
          if (imem.imem_rvalid) state_next = REQ;
        end
        default: state_next = REQ;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = (state == REQ) && !reset;
    imem.imem_addr = pc;
    load_valid     = (state == WAIT) && imem.imem_rvalid && !branch_taken;
  end

  if_id_skid #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .flush        (branch_taken),
    .in_valid     (load_valid),
    .in_inst      (imem.imem_rdata),
    .in_pc        (pc),
    .in_ready     (slot_free),
    .decode_ready (decode_ready),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid),
    .hold_valid   (hold_valid)
  );

endmodule
